// File: rtl/sym_err_meter.sv
// Symbol-error meter for the 4-ASK in-phase rail: self-aligns to the slicer delay,
// then counts symbol and bit errors over windows framed by the LFSR cycle pulse.
module sym_err_meter #(
    parameter int MAX_DELAY   = 7,
    parameter int DLY_W       = 3,
    parameter int CNT_W       = 22,
    parameter int TRIAL_LEN   = 64,
    parameter int LOCK_THRESH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             hold,
    input  logic [1:0]       sym_ref,
    input  logic [1:0]       sym_rx,
    output logic             locked,
    output logic [DLY_W-1:0] delay_sel,
    output logic             sym_err,
    output logic [CNT_W-1:0] sym_cnt,
    output logic [CNT_W-1:0] sym_err_cnt,
    output logic [CNT_W:0]   bit_err_cnt,
    output logic             meas_valid,
    output logic             meas_clean
);

    localparam int TC_W = (TRIAL_LEN > 1) ? $clog2(TRIAL_LEN) : 1;
    localparam int TE_W = $clog2(TRIAL_LEN + 2);

    typedef enum logic {
        ALIGN = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [DLY_W-1:0] delay_d;
    logic [DLY_W-1:0] delay_inc;

    logic [1:0]       tap_q [1:MAX_DELAY];
    logic [1:0]       ref_sym;
    logic [1:0]       diff;
    logic             mis;
    logic [1:0]       nbit;

    logic [TC_W-1:0]  trial_cnt;
    logic [TE_W-1:0]  trial_err;
    logic [TE_W-1:0]  errs_total;
    logic             trial_end;
    logic             trial_pass;

    logic             tracking;
    logic [CNT_W-1:0] acc_sym;
    logic [CNT_W-1:0] acc_err;
    logic [CNT_W:0]   acc_bit;
    logic             acc_clean;
    logic [CNT_W-1:0] sym_next;
    logic [CNT_W-1:0] err_next;
    logic [CNT_W:0]   bit_next;
    logic [CNT_W+1:0] bit_sum;

    // Reference tap select uses the taps before this enable's shift.
    always_comb begin
        ref_sym = sym_ref;
        for (int i = 1; i <= MAX_DELAY; i++) begin
            if (delay_sel == DLY_W'(i)) begin
                ref_sym = tap_q[i];
            end
        end
    end

    assign diff       = sym_rx ^ ref_sym;
    assign mis        = |diff;
    assign nbit       = {1'b0, diff[1]} + {1'b0, diff[0]};
    assign trial_end  = (trial_cnt == TC_W'(TRIAL_LEN - 1));
    assign errs_total = trial_err + TE_W'(mis);
    assign trial_pass = (errs_total <= TE_W'(LOCK_THRESH));
    assign delay_inc  = (delay_sel == DLY_W'(MAX_DELAY)) ? '0 : delay_sel + 1'b1;
    assign tracking   = (state_q == TRACK);
    assign locked     = tracking;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i <= MAX_DELAY; i++) begin
                tap_q[i] <= 2'b00;
            end
        end else if (clk_en) begin
            tap_q[1] <= sym_ref;
            for (int i = 2; i <= MAX_DELAY; i++) begin
                tap_q[i] <= tap_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trial_cnt <= '0;
            trial_err <= '0;
        end else if (clk_en) begin
            if (trial_end) begin
                trial_cnt <= '0;
                trial_err <= '0;
            end else begin
                trial_cnt <= trial_cnt + 1'b1;
                if (mis && (trial_err != TE_W'(TRIAL_LEN))) begin
                    trial_err <= trial_err + 1'b1;
                end
            end
        end
    end

    // A failed trial always moves to the next candidate delay, whether searching or tracking.
    always_comb begin
        state_d = state_q;
        delay_d = delay_sel;
        if (clk_en && trial_end) begin
            case (state_q)
                ALIGN: begin
                    if (trial_pass) begin
                        state_d = TRACK;
                    end else begin
                        delay_d = delay_inc;
                    end
                end
                TRACK: begin
                    if (!trial_pass) begin
                        state_d = ALIGN;
                        delay_d = delay_inc;
                    end
                end
                default: state_d = ALIGN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ALIGN;
            delay_sel <= '0;
        end else begin
            state_q   <= state_d;
            delay_sel <= delay_d;
        end
    end

    // Saturating window sums including the current symbol's contribution.
    assign sym_next = (!tracking || (acc_sym == '1)) ? acc_sym : acc_sym + 1'b1;
    assign err_next = (!(tracking && mis) || (acc_err == '1)) ? acc_err : acc_err + 1'b1;
    assign bit_sum  = {1'b0, acc_bit} + {{CNT_W{1'b0}}, (tracking ? nbit : 2'b00)};
    assign bit_next = bit_sum[CNT_W+1] ? '1 : bit_sum[CNT_W:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_sym     <= '0;
            acc_err     <= '0;
            acc_bit     <= '0;
            acc_clean   <= 1'b1;
            sym_cnt     <= '0;
            sym_err_cnt <= '0;
            bit_err_cnt <= '0;
            meas_valid  <= 1'b0;
            meas_clean  <= 1'b0;
            sym_err     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (clk_en) begin
                sym_err <= (state_d == TRACK) && mis;
                if (hold) begin
                    sym_cnt     <= sym_next;
                    sym_err_cnt <= err_next;
                    bit_err_cnt <= bit_next;
                    meas_clean  <= acc_clean && tracking;
                    meas_valid  <= 1'b1;
                    acc_sym     <= '0;
                    acc_err     <= '0;
                    acc_bit     <= '0;
                    acc_clean   <= 1'b1;
                end else begin
                    acc_sym <= sym_next;
                    acc_err <= err_next;
                    acc_bit <= bit_next;
                    if (!tracking) begin
                        acc_clean <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sym_err_meter.sv
// Bench for sym_err_meter: directed channel scenarios, a symbol-level reference model
// checked every cycle, and literal expectations for the key measurement points.
module tb_sym_err_meter;

    localparam int TRIAL = 64;
    localparam int MAXD  = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        hold;
    logic [1:0]  sym_ref;
    logic [1:0]  sym_rx;

    logic        locked, s_locked;
    logic [2:0]  delay_sel, s_delay_sel;
    logic        sym_err, s_sym_err;
    logic [21:0] sym_cnt, sym_err_cnt;
    logic [22:0] bit_err_cnt;
    logic [3:0]  s_sym_cnt, s_sym_err_cnt;
    logic [4:0]  s_bit_err_cnt;
    logic        meas_valid, meas_clean, s_meas_valid, s_meas_clean;

    int n_checks = 0;
    int n_pass   = 0;

    sym_err_meter dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .hold(hold),
        .sym_ref(sym_ref), .sym_rx(sym_rx),
        .locked(locked), .delay_sel(delay_sel), .sym_err(sym_err),
        .sym_cnt(sym_cnt), .sym_err_cnt(sym_err_cnt), .bit_err_cnt(bit_err_cnt),
        .meas_valid(meas_valid), .meas_clean(meas_clean)
    );

    sym_err_meter #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .clk_en(clk_en), .hold(hold),
        .sym_ref(sym_ref), .sym_rx(sym_rx),
        .locked(s_locked), .delay_sel(s_delay_sel), .sym_err(s_sym_err),
        .sym_cnt(s_sym_cnt), .sym_err_cnt(s_sym_err_cnt), .bit_err_cnt(s_bit_err_cnt),
        .meas_valid(s_meas_valid), .meas_clean(s_meas_clean)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Reference model: symbol history queue, trial tallies and unbounded window totals.
    int  m_hist[$];
    int  m_delay, t_cnt, t_err, m_mis, m_nb, ref_now, diff_v;
    bit  m_track, trk, started = 1'b0;
    int  w_sym, w_err, w_bit;
    bit  w_clean;
    int  e_sym, e_err, e_bit;
    bit  e_valid, e_clean, e_sym_err;

    always @(posedge clk) begin
        if (reset) begin
            m_track = 0; m_delay = 0; t_cnt = 0; t_err = 0;
            w_sym = 0; w_err = 0; w_bit = 0; w_clean = 1;
            e_sym = 0; e_err = 0; e_bit = 0; e_valid = 0; e_clean = 0; e_sym_err = 0;
            m_hist = {};
            repeat (MAXD) m_hist.push_back(0);
            started = 1;
        end else begin
            e_valid = 0;
            if (clk_en) begin
                ref_now = (m_delay == 0) ? int'(sym_ref) : m_hist[m_delay-1];
                diff_v  = int'(sym_rx) ^ ref_now;
                m_mis   = (diff_v != 0) ? 1 : 0;
                m_nb    = (diff_v & 1) + (diff_v >> 1);
                trk     = m_track;
                if (hold) begin
                    e_sym   = w_sym + (trk ? 1 : 0);
                    e_err   = w_err + (trk ? m_mis : 0);
                    e_bit   = w_bit + (trk ? m_nb : 0);
                    e_clean = w_clean && trk;
                    e_valid = 1;
                    w_sym = 0; w_err = 0; w_bit = 0; w_clean = 1;
                end else if (trk) begin
                    w_sym += 1; w_err += m_mis; w_bit += m_nb;
                end else begin
                    w_clean = 0;
                end
                t_cnt += 1;
                t_err += m_mis;
                if (t_cnt == TRIAL) begin
                    if (t_err > 2) begin
                        m_track = 0;
                        m_delay = (m_delay + 1) % (MAXD + 1);
                    end else begin
                        m_track = 1;
                    end
                    t_cnt = 0;
                    t_err = 0;
                end
                e_sym_err = m_track ? m_mis[0] : 1'b0;
                m_hist.push_front(int'(sym_ref));
                void'(m_hist.pop_back());
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checkOutput("locked", locked, m_track);
            checkOutput("delay_sel", delay_sel, m_delay);
            checkOutput("sym_err", sym_err, e_sym_err);
            checkOutput("sym_cnt", sym_cnt, sat(e_sym, 22'h3FFFFF));
            checkOutput("sym_err_cnt", sym_err_cnt, sat(e_err, 22'h3FFFFF));
            checkOutput("bit_err_cnt", bit_err_cnt, sat(e_bit, 23'h7FFFFF));
            checkOutput("meas_valid", meas_valid, e_valid);
            checkOutput("meas_clean", meas_clean, e_clean);
            checkOutput("s_locked", s_locked, m_track);
            checkOutput("s_delay_sel", s_delay_sel, m_delay);
            checkOutput("s_sym_err", s_sym_err, e_sym_err);
            checkOutput("s_sym_cnt", s_sym_cnt, sat(e_sym, 15));
            checkOutput("s_sym_err_cnt", s_sym_err_cnt, sat(e_err, 15));
            checkOutput("s_bit_err_cnt", s_bit_err_cnt, sat(e_bit, 31));
            checkOutput("s_meas_valid", s_meas_valid, e_valid);
            checkOutput("s_meas_clean", s_meas_clean, e_clean);
        end
    end

    // Channel: received symbol is the transmitted one delayed by chan_delay symbols.
    logic [1:0] chan_hist[$];
    int         chan_delay = 3;
    int         n_sym = 0;

    task automatic applyStimulus(input logic en, input logic h, input logic [1:0] r, input logic [1:0] x);
        @(negedge clk);
        clk_en  = en;
        hold    = h;
        sym_ref = r;
        sym_rx  = x;
    endtask

    task automatic sendSym(input logic [1:0] flip, input logic h, input logic gap_hold);
        logic [1:0] r;
        logic [1:0] x;
        r = 2'($urandom_range(0, 3));
        x = ((chan_delay == 0) ? r : chan_hist[chan_delay-1]) ^ flip;
        applyStimulus(1'b1, h, r, x);
        chan_hist.push_front(r);
        void'(chan_hist.pop_back());
        n_sym++;
        applyStimulus(1'b0, gap_hold, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b0; hold = 1'b0; sym_ref = 2'b00; sym_rx = 2'b00;

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        @(negedge clk);
        reset = 1'b0; clk_en = 1'b0; hold = 1'b0;
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_delay_sel", delay_sel, 0);
        checkOutput("rst_sym_err", sym_err, 0);
        checkOutput("rst_sym_cnt", sym_cnt, 0);
        checkOutput("rst_bit_err_cnt", bit_err_cnt, 0);
        checkOutput("rst_meas_valid", meas_valid, 0);
        checkOutput("rst_meas_clean", meas_clean, 0);
        chan_hist = {};
        repeat (8) chan_hist.push_back(2'b00);
        n_sym = 0;
        chan_delay = 3;

        // Acquisition: delays 0,1,2 fail, delay 3 passes on the fourth trial.
        for (int i = 1; i <= 256; i++) begin
            sendSym(2'b00, 1'b0, 1'b0);
            if (i == 64)  checkOutput("acq_delay_1", delay_sel, 1);
            if (i == 128) checkOutput("acq_delay_2", delay_sel, 2);
            if (i == 192) checkOutput("acq_delay_3", delay_sel, 3);
            if (i == 255) checkOutput("acq_unlocked_255", locked, 0);
        end
        checkOutput("acq_locked", locked, 1);
        checkOutput("acq_delay", delay_sel, 3);

        // LSB flips on 5 of 1000 symbols.
        sendSym(2'b00, 1'b1, 1'b0);
        for (int i = 1; i <= 1000; i++)
            sendSym((i % 200 == 100) ? 2'b01 : 2'b00, i == 1000, 1'b0);
        checkOutput("w1_sym_cnt", sym_cnt, 1000);
        checkOutput("w1_sym_err_cnt", sym_err_cnt, 5);
        checkOutput("w1_bit_err_cnt", bit_err_cnt, 5);
        checkOutput("w1_meas_clean", meas_clean, 1);
        checkOutput("w1_meas_valid", meas_valid, 1);
        checkOutput("w1_s_sym_cnt", s_sym_cnt, 15);
        checkOutput("w1_s_bit_err_cnt", s_bit_err_cnt, 5);

        // Both bits flipped on 5 symbols; hold also raised while clk_en is low.
        for (int i = 1; i <= 1000; i++) begin
            sendSym((i % 200 == 100) ? 2'b11 : 2'b00, i == 1000, 1'b1);
            if (i == 2) begin
                checkOutput("gap_hold_valid", meas_valid, 0);
                checkOutput("gap_hold_sym_cnt", sym_cnt, 1000);
            end
        end
        checkOutput("w2_sym_cnt", sym_cnt, 1000);
        checkOutput("w2_sym_err_cnt", sym_err_cnt, 5);
        checkOutput("w2_bit_err_cnt", bit_err_cnt, 10);
        checkOutput("w2_meas_clean", meas_clean, 1);
        checkOutput("w2_s_bit_err_cnt", s_bit_err_cnt, 10);

        // Channel delay jumps from 3 to 5 exactly at a trial boundary.
        while (n_sym % TRIAL != 0) sendSym(2'b00, 1'b0, 1'b0);
        chan_delay = 5;
        for (int i = 0; i < TRIAL; i++) sendSym(2'b00, 1'b0, 1'b0);
        checkOutput("slip_unlocked", locked, 0);
        checkOutput("slip_delay_4", delay_sel, 4);
        for (int i = 0; i < TRIAL; i++) sendSym(2'b00, 1'b0, 1'b0);
        checkOutput("slip_delay_5", delay_sel, 5);
        for (int i = 0; i < TRIAL; i++) sendSym(2'b00, 1'b0, 1'b0);
        checkOutput("relock_locked", locked, 1);
        checkOutput("relock_delay", delay_sel, 5);
        for (int i = 1; i <= 20; i++) sendSym(2'b00, i == 20, 1'b0);
        checkOutput("slip_meas_clean", meas_clean, 0);
        checkOutput("slip_meas_valid", meas_valid, 1);

        // 40 clean symbols: the 4-bit instance saturates at 15.
        for (int i = 1; i <= 40; i++) sendSym(2'b00, i == 40, 1'b0);
        checkOutput("sat_sym_cnt", sym_cnt, 40);
        checkOutput("sat_s_sym_cnt", s_sym_cnt, 15);
        checkOutput("sat_s_err_cnt", s_sym_err_cnt, 0);
        checkOutput("sat_s_meas_clean", s_meas_clean, 1);

        // Window close on the same symbol as a failing trial end.
        while (n_sym % TRIAL != TRIAL - 1) sendSym(2'b00, 1'b0, 1'b0);
        sendSym(2'b00, 1'b1, 1'b0);
        chan_delay = 2;
        for (int i = 1; i <= TRIAL; i++) sendSym(2'b00, i == TRIAL, 1'b0);
        checkOutput("coinc_sym_cnt", sym_cnt, 64);
        checkOutput("coinc_meas_clean", meas_clean, 1);
        checkOutput("coinc_meas_valid", meas_valid, 1);
        checkOutput("coinc_unlocked", locked, 0);
        checkOutput("coinc_delay", delay_sel, 6);
        checkOutput("coinc_s_sym_cnt", s_sym_cnt, 15);

        // Reset in the middle of a window, coincident with hold.
        for (int i = 0; i < 10; i++) sendSym(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1; clk_en = 1'b1; hold = 1'b1;
        @(negedge clk);
        reset = 1'b0; clk_en = 1'b0; hold = 1'b0;
        checkOutput("midrst_valid", meas_valid, 0);
        checkOutput("midrst_sym_cnt", sym_cnt, 0);
        checkOutput("midrst_delay", delay_sel, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
